// File: rtl/hack_pkg.sv
// Shared Hack platform definitions: instruction memory geometry and the
// program loader state encoding.
package hack_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int ROM_DATA_W = 16;
  localparam int ROM_DEPTH  = 32768;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LEN_HI  = 4'd1,
    ST_LEN_LO  = 4'd2,
    ST_DATA_HI = 4'd3,
    ST_DATA_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CSUM_HI = 4'd6,
    ST_CSUM_LO = 4'd7,
    ST_DONE    = 4'd8,
    ST_ERROR   = 4'd9
  } loader_state_e;

  // States in which the loader consumes a byte from the receiver.
  function automatic logic takes_byte(input loader_state_e s);
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM_HI, ST_CSUM_LO:
        takes_byte = 1'b1;
      default:
        takes_byte = 1'b0;
    endcase
  endfunction

  function automatic logic is_busy(input loader_state_e s);
    case (s)
      ST_IDLE, ST_DONE, ST_ERROR: is_busy = 1'b0;
      default:                    is_busy = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
interface rom_loader_if;
  import hack_pkg::*;

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ROM_ADDR_W-1:0] mem_addr;
  logic [ROM_DATA_W-1:0] mem_wdata;
  logic                  mem_we;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/rom_loader.sv
// Hack instruction-RAM program loader: framed big-endian byte stream to
// sequential word writes. Optional trailing checksum via ROM_LOADER_CHECKSUM_EN.
module rom_loader
  import hack_pkg::*;
#(
  parameter int MAX_WORDS = ROM_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_req,
  rom_loader_if.slave bus,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error
);

  loader_state_e         state_q, state_d;
  logic [7:0]            hi_q, hi_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           addr_q, addr_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  mem_we_q, mem_we_d;
  logic [ROM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ROM_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0]           csum_q, csum_d;
`endif

  logic        accept_s;
  logic [15:0] byte_word_s;
  logic        len_bad_s;
  logic        last_word_s;

  assign accept_s    = bus.in_valid & in_ready_q;
  assign byte_word_s = {hi_q, bus.in_data};
  assign len_bad_s   = (byte_word_s == 16'd0) || ({1'b0, byte_word_s} > 17'(MAX_WORDS));
  // The counter is 16 bits so that a 32768-word load terminates at 0x7FFF.
  assign last_word_s = (addr_q == (len_q - 16'd1));

  // Next-state and next-output computation for the whole loader.
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    len_d       = len_q;
    addr_d      = addr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    error_d     = error_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_req) begin
          state_d = ST_LEN_HI;
          done_d  = 1'b0;
          error_d = 1'b0;
          addr_d  = 16'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
          csum_d  = 16'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          hi_d    = bus.in_data;
          state_d = ST_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_d = byte_word_s;
          if (len_bad_s) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = ST_DATA_HI;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA_HI: begin
        if (accept_s) begin
          hi_d    = bus.in_data;
          state_d = ST_DATA_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA_LO: begin
        if (accept_s) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q[ROM_ADDR_W-1:0];
          mem_wdata_d = byte_word_s;
          state_d     = ST_WRITE;
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_d = csum_q + mem_wdata_q;
`endif
        if (last_word_s) begin
`ifdef ROM_LOADER_CHECKSUM_EN
          state_d = ST_CSUM_HI;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = ST_DATA_HI;
        end
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      ST_CSUM_HI: begin
        if (accept_s) begin
          hi_d    = bus.in_data;
          state_d = ST_CSUM_LO;
        end else begin
          state_d = state_q;
        end
      end
      ST_CSUM_LO: begin
        if (accept_s) begin
          if (byte_word_s == csum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake and status outputs are registered from the next state.
    in_ready_d = takes_byte(state_d);
    busy_d     = is_busy(state_d);
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hi_q        <= 8'd0;
      len_q       <= 16'd0;
      addr_q      <= 16'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q      <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign cpu_hold      = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: randomized frames against a frame-level
// reference model. Honours ROM_LOADER_CHECKSUM_EN like the design.
module tb_rom_loader;
  import hack_pkg::*;

  typedef logic [7:0]  byte_q_t [$];
  typedef logic [15:0] word_q_t [$];

  logic clk = 1'b0;
  logic rst_n;
  logic load_req;
  logic cpu_hold, busy, done, error;

  rom_loader_if bus ();

  rom_loader #(.MAX_WORDS(ROM_DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_req (load_req),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [14:0] wr_addr_q [$];
  logic [15:0] wr_data_q [$];
  logic [14:0] exp_addr_q [$];
  logic [15:0] exp_data_q [$];

  // Observed instruction-RAM writes.
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
  end

  function automatic byte_q_t build_frame(input word_q_t words);
    byte_q_t f;
    logic [15:0] n;
    logic [15:0] sum;
    n   = 16'(words.size());
    sum = 16'd0;
    f.push_back(n[15:8]);
    f.push_back(n[7:0]);
    foreach (words[i]) begin
      f.push_back(words[i][15:8]);
      f.push_back(words[i][7:0]);
      sum = sum + words[i];
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    f.push_back(sum[15:8]);
    f.push_back(sum[7:0]);
`endif
    return f;
  endfunction

  // Reference: what a frame must produce (writes, final status, status latency).
  task automatic model_frame(input byte_q_t f, output bit exp_err, output int exp_lat);
    int n;
    logic [15:0] w;
    logic [15:0] sum;
    exp_addr_q.delete();
    exp_data_q.delete();
    n = {f[0], f[1]};
    sum = 16'd0;
    exp_err = 1'b0;
    if (n == 0 || n > ROM_DEPTH) begin
      exp_err = 1'b1;
      exp_lat = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = {f[2 + 2 * k], f[3 + 2 * k]};
      exp_addr_q.push_back(k[14:0]);
      exp_data_q.push_back(w);
      sum = sum + w;
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    exp_err = (sum != {f[2 + 2 * n], f[3 + 2 * n]});
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    if (gap) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && t < 50) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      errors++;
      checks++;
      $display("FAIL send_byte: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic pulse_load;
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic run_frame(input byte_q_t f, input bit gaps, input int pulse_at, input string name);
    bit exp_err;
    int exp_lat;
    int lat;
    int bad;
    model_frame(f, exp_err, exp_lat);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_load();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b hold=%b done=%b err=%b, required 1 1 0 0",
               name, busy, cpu_hold, done, error);
    end
    foreach (f[i]) begin
      if (i == pulse_at) pulse_load();
      send_byte(f[i], gaps);
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && exp_lat == 2) begin
        checks++;
        if (bus.mem_we !== 1'b1 || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s write_latency: mem_we=%b in_ready=%b, required 1 0",
                   name, bus.mem_we, bus.in_ready);
        end
      end
    end while (done !== 1'b1 && error !== 1'b1 && lat < 20);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s status_latency: %0d cycles, required %0d", name, lat, exp_lat);
    end
    checks++;
    if (done !== !exp_err || error !== exp_err || busy !== 1'b0 || cpu_hold !== 1'b0
        || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s status: done=%b err=%b busy=%b hold=%b rdy=%b, required %b %b 0 0 0",
               name, done, error, busy, cpu_hold, bus.in_ready, !exp_err, exp_err);
    end
    checks++;
    bad = -1;
    if (wr_addr_q.size() != exp_addr_q.size()) begin
      errors++;
      $display("FAIL %s write_count: %0d writes, required %0d", name, wr_addr_q.size(), exp_addr_q.size());
    end else begin
      foreach (exp_addr_q[i]) begin
        if (bad < 0 && (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i])) bad = i;
      end
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s write_data: #%0d addr=%h data=%h, required addr=%h data=%h", name, bad,
                 wr_addr_q[bad], wr_data_q[bad], exp_addr_q[bad], exp_data_q[bad]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    load_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0
        || done !== 1'b0 || error !== 1'b0 || bus.mem_addr !== 15'd0 || bus.mem_wdata !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b we=%b hold=%b busy=%b done=%b err=%b addr=%h data=%h, required all 0",
               bus.in_ready, bus.mem_we, cpu_hold, busy, done, error, bus.mem_addr, bus.mem_wdata);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL idle_no_consume: busy=%b rdy=%b writes=%0d, required 0 0 0",
               busy, bus.in_ready, wr_addr_q.size());
    end
  endtask

  task automatic test_basic;
    word_q_t w;
    w = {16'h1234, 16'hABCD};
    run_frame(build_frame(w), 1'b0, -1, "basic");
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 15'd0 || wr_data_q[0] !== 16'h1234
        || wr_addr_q[1] !== 15'd1 || wr_data_q[1] !== 16'hABCD || done !== 1'b1) begin
      errors++;
      $display("FAIL basic_literal: %0d writes done=%b, required 0:1234 1:ABCD done=1",
               wr_addr_q.size(), done);
    end
  endtask

  task automatic test_bad_len;
    byte_q_t f;
    f = {8'h00, 8'h00};
    run_frame(f, 1'b0, -1, "len_zero");
    f = {8'h80, 8'h01};
    run_frame(f, 1'b1, -1, "len_over");
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0 || wr_addr_q.size() != 0) begin
      errors++;
      $display("FAIL error_hold: err=%b rdy=%b busy=%b writes=%0d, required 1 0 0 0",
               error, bus.in_ready, busy, wr_addr_q.size());
    end
  endtask

`ifdef ROM_LOADER_CHECKSUM_EN
  task automatic test_csum_mismatch;
    byte_q_t f;
    f = {8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h06};
    run_frame(f, 1'b0, -1, "csum_bad");
    checks++;
    if (error !== 1'b1 || wr_data_q.size() != 1 || wr_data_q[0] !== 16'h0005) begin
      errors++;
      $display("FAIL csum_bad_literal: err=%b writes=%0d, required err=1 one write of 0005",
               error, wr_data_q.size());
    end
  endtask
`endif

  task automatic test_random;
    word_q_t w;
    byte_q_t f;
    for (int r = 0; r < 6; r++) begin
      w.delete();
      repeat ($urandom_range(1, 8)) w.push_back(16'($urandom));
      f = build_frame(w);
`ifdef ROM_LOADER_CHECKSUM_EN
      if (r == 3) f[f.size() - 1] = f[f.size() - 1] ^ 8'h01;
`endif
      if (r == 5) begin
        f = {8'h80 | 8'($urandom_range(0, 127)), 8'($urandom_range(1, 255))};
      end
      run_frame(f, 1'b1, -1, "random");
    end
  endtask

  task automatic test_busy_req;
    word_q_t w;
    for (int i = 0; i < 4; i++) w.push_back(16'($urandom));
    run_frame(build_frame(w), 1'b1, 5, "busy_req");
  endtask

  task automatic test_reset_midload;
    word_q_t w;
    byte_q_t f;
    for (int i = 0; i < 5; i++) w.push_back(16'h0100 + 16'(i));
    f = build_frame(w);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_load();
    for (int i = 0; i < 9; i++) send_byte(f[i], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.mem_we !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0
        || done !== 1'b0 || error !== 1'b0 || bus.mem_addr !== 15'd0 || bus.mem_wdata !== 16'd0) begin
      errors++;
      $display("FAIL midload_reset: rdy=%b we=%b hold=%b busy=%b addr=%h data=%h, required all 0",
               bus.in_ready, bus.mem_we, cpu_hold, busy, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != 3 || wr_addr_q[2] !== 15'd2 || wr_data_q[2] !== 16'h0102) begin
      errors++;
      $display("FAIL midload_writes: %0d writes, required 3 ending at addr 2", wr_addr_q.size());
    end
    w.delete();
    for (int i = 0; i < 3; i++) w.push_back(16'($urandom));
    run_frame(build_frame(w), 1'b1, -1, "after_reset");
  endtask

  task automatic test_full;
    word_q_t w;
    int zero_hits;
    for (int k = 0; k < ROM_DEPTH; k++) w.push_back(16'(k));
    run_frame(build_frame(w), 1'b0, -1, "full");
    zero_hits = 0;
    foreach (wr_addr_q[i]) if (wr_addr_q[i] == 15'd0) zero_hits++;
    checks++;
    if (zero_hits != 1 || wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size() - 1] !== 15'h7FFF
        || done !== 1'b1) begin
      errors++;
      $display("FAIL full_boundary: addr0 writes=%0d total=%0d done=%b, required 1 32768 1",
               zero_hits, wr_addr_q.size(), done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_len();
`ifdef ROM_LOADER_CHECKSUM_EN
    test_csum_mismatch();
`endif
    test_random();
    test_busy_req();
    test_reset_midload();
    test_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
